// File: rtl/uarc_receiver_arbiter.sv
// rtl/uarc_receiver_arbiter.sv - UARC receive-side kill/send arbiter with one held message port
// Define UARC_RECEIVER_ROUND_ROBIN_EN for rotating fairness; otherwise lowest index wins.
module uarc_receiver_arbiter #(
  parameter  int WORD_MAG    = 5,
  parameter  int TOTAL_BUSES = 4,
  localparam int WORD_WIDTH  = 1 << WORD_MAG,
  localparam int IDX_WIDTH   = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [TOTAL_BUSES-1:0]                  receiver_enable,
  input  logic [TOTAL_BUSES-1:0]                  receiver_kills,
  output logic [TOTAL_BUSES-1:0]                  receiver_kill_acks,
  input  logic [TOTAL_BUSES-1:0]                  receiver_sends,
  output logic [TOTAL_BUSES-1:0]                  receiver_send_acks,
  input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]  receiver_datas,
  input  logic                                    interrupt_en,
  output logic                                    msg_valid,
  output logic                                    msg_kill,
  output logic [IDX_WIDTH-1:0]                    msg_bus,
  output logic [WORD_WIDTH-1:0]                   msg_data,
  input  logic                                    msg_ready
);

  localparam logic [IDX_WIDTH:0] NB = (IDX_WIDTH+1)'(TOTAL_BUSES);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state, state_next;
  logic [TOTAL_BUSES-1:0] kill_elig, send_elig, cand, onehot;
  logic                   kill_class, found, grant;
  logic [IDX_WIDTH-1:0]   winner, search_base;
  logic [IDX_WIDTH:0]     idx;

  assign kill_elig  = receiver_kills & receiver_enable;
  assign send_elig  = receiver_sends & receiver_enable & {TOTAL_BUSES{interrupt_en}};
  assign kill_class = |kill_elig;
  assign cand       = kill_class ? kill_elig : send_elig;
  assign msg_valid  = (state == HOLD);

`ifdef UARC_RECEIVER_ROUND_ROBIN_EN
  logic [IDX_WIDTH-1:0] rr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (grant)
      rr_ptr <= ({1'b0, winner} == NB - 1'b1) ? '0 : winner + 1'b1;
  end

  assign search_base = rr_ptr;
`else
  assign search_base = '0;
`endif

  // Scan from search_base upward with wrap at TOTAL_BUSES (not at a power of two).
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < TOTAL_BUSES; i++) begin
      idx = {1'b0, search_base} + (IDX_WIDTH+1)'(i);
      if (idx >= NB)
        idx = idx - NB;
      if (!found && cand[idx[IDX_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_WIDTH-1:0];
      end
    end
  end

  assign onehot = TOTAL_BUSES'(1) << winner;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    case (state)
      IDLE: if (found) begin
        grant      = 1'b1;
        state_next = HOLD;
      end
      HOLD: if (msg_ready)
        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Acks are one-cycle pulses; message fields stay frozen until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      msg_kill           <= 1'b0;
      msg_bus            <= '0;
      msg_data           <= '0;
      receiver_kill_acks <= '0;
      receiver_send_acks <= '0;
    end else begin
      receiver_kill_acks <= '0;
      receiver_send_acks <= '0;
      if (grant) begin
        msg_kill <= kill_class;
        msg_bus  <= winner;
        msg_data <= kill_class ? '0 : receiver_datas[winner];
        if (kill_class)
          receiver_kill_acks <= onehot;
        else
          receiver_send_acks <= onehot;
      end
    end
  end

endmodule

// File: tb/tb_uarc_receiver_arbiter.sv
// tb/tb_uarc_receiver_arbiter.sv - randomized self-checking bench for uarc_receiver_arbiter
// Reference model picks the eligible bus with the smallest rotated distance from the pointer.
module tb_uarc_receiver_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;
`ifdef UARC_RECEIVER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      enable = '1, kills = '0, sends = '0;
  logic [N-1:0]      kill_acks, send_acks;
  logic [N-1:0][W-1:0] datas = '0;
  logic              interrupt_en = 1'b1, msg_ready = 1'b0;
  logic              msg_valid, msg_kill;
  logic [IW-1:0]     msg_bus;
  logic [W-1:0]      msg_data;

  int total = 0;
  int bad   = 0;

  bit           m_hold;
  int           m_ptr, m_bus;
  bit           m_kill;
  logic [W-1:0] m_data;
  logic [N-1:0] m_kack, m_sack;

  always #5 clk = ~clk;

  uarc_receiver_arbiter #(.WORD_MAG(5), .TOTAL_BUSES(N)) dut (
    .clk(clk), .reset(reset),
    .receiver_enable(enable),
    .receiver_kills(kills), .receiver_kill_acks(kill_acks),
    .receiver_sends(sends), .receiver_send_acks(send_acks),
    .receiver_datas(datas),
    .interrupt_en(interrupt_en),
    .msg_valid(msg_valid), .msg_kill(msg_kill), .msg_bus(msg_bus),
    .msg_data(msg_data), .msg_ready(msg_ready)
  );

  task automatic model_reset();
    m_hold = 1'b0;
    m_ptr  = 0;
    m_kack = '0;
    m_sack = '0;
  endtask

  // Predict the next cycle from the current inputs, then advance one clock.
  task automatic tick();
    logic [N-1:0] ke, cand;
    bit k;
    int best, bestd, d;
    m_kack = '0;
    m_sack = '0;
    if (!m_hold) begin
      ke   = kills & enable;
      k    = |ke;
      cand = k ? ke : (sends & enable & {N{interrupt_en}});
      best = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        d = (i - m_ptr + N) % N;
        if (cand[i] && d < bestd) begin
          best  = i;
          bestd = d;
        end
      end
      if (best >= 0) begin
        m_hold = 1'b1;
        m_bus  = best;
        m_kill = k;
        m_data = k ? '0 : datas[best];
        if (k) m_kack[best] = 1'b1;
        else   m_sack[best] = 1'b1;
        if (RR) m_ptr = (best + 1) % N;
      end
    end else if (msg_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    sends = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({msg_valid, msg_kill, msg_bus, msg_data, kill_acks, send_acks} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b k=%b bus=%0d data=%h ka=%b sa=%b, want all 0",
               msg_valid, msg_kill, msg_bus, msg_data, kill_acks, send_acks);
    end
    model_reset();
    reset = 1'b1;
    tick();
    total++;
    if (send_acks !== 4'b0001 || kill_acks !== 4'b0000 || msg_bus !== 2'd0 || msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL first_grant: got sa=%b ka=%b bus=%0d v=%b, want sa=0001 ka=0000 bus=0 v=1",
               send_acks, kill_acks, msg_bus, msg_valid);
    end
    sends = '0;
    msg_ready = 1'b1;
    tick();
    total++;
    if (send_acks !== 4'b0000 || msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL ack_one_cycle: got sa=%b v=%b, want sa=0000 v=0", send_acks, msg_valid);
    end
  endtask

  task automatic test_kill_priority();
    msg_ready = 1'b0;
    sends = 4'b0010;
    kills = 4'b1000;
    datas[3] = 32'h1234_5678;
    tick();
    total++;
    if (kill_acks !== 4'b1000 || send_acks !== 4'b0000 || msg_kill !== 1'b1 ||
        msg_bus !== 2'd3 || msg_data !== 32'h0) begin
      bad++;
      $display("FAIL kill_priority: got ka=%b sa=%b k=%b bus=%0d data=%h, want ka=1000 sa=0000 k=1 bus=3 data=0",
               kill_acks, send_acks, msg_kill, msg_bus, msg_data);
    end
    kills = '0;
    msg_ready = 1'b1;
    tick();
    msg_ready = 1'b0;
    tick();
    total++;
    if (send_acks !== 4'b0010 || msg_kill !== 1'b0 || msg_bus !== 2'd1) begin
      bad++;
      $display("FAIL send_after_kill: got sa=%b k=%b bus=%0d, want sa=0010 k=0 bus=1",
               send_acks, msg_kill, msg_bus);
    end
    sends = '0;
    msg_ready = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[4];
    pulse_reset();
    sends = 4'b1011;
    msg_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if ({msg_valid, kill_acks, send_acks} !== {m_hold, m_kack, m_sack}) begin
        bad++;
        $display("FAIL rr_cycle%0d: got v=%b ka=%b sa=%b, want v=%b ka=%b sa=%b",
                 c, msg_valid, kill_acks, send_acks, m_hold, m_kack, m_sack);
      end
      for (int i = 0; i < N; i++)
        if (send_acks[i]) order.push_back(i);
    end
    if (RR) exp_order = '{0, 1, 3, 0};
    else    exp_order = '{0, 0, 0, 0};
    total++;
    if (order.size() != 4) begin
      bad++;
      $display("FAIL rr_grant_count: got %0d grants, want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] != exp_order[i]) begin
          bad++;
          $display("FAIL rr_order%0d: got bus %0d, want bus %0d", i, order[i], exp_order[i]);
        end
      end
    end
    sends = '0;
    tick();
    tick();
  endtask

  task automatic test_gating();
    msg_ready = 1'b1;
    interrupt_en = 1'b0;
    sends = 4'b0100;
    repeat (3) begin
      tick();
      total++;
      if (send_acks !== 4'b0000 || kill_acks !== 4'b0000 || msg_valid !== 1'b0) begin
        bad++;
        $display("FAIL gate_int_en: got sa=%b ka=%b v=%b, want no ack", send_acks, kill_acks, msg_valid);
      end
    end
    sends = '0;
    enable = 4'b1011;
    kills = 4'b0100;
    repeat (3) begin
      tick();
      total++;
      if (send_acks !== 4'b0000 || kill_acks !== 4'b0000 || msg_valid !== 1'b0) begin
        bad++;
        $display("FAIL gate_enable: got sa=%b ka=%b v=%b, want no ack", send_acks, kill_acks, msg_valid);
      end
    end
    kills = '0;
    enable = '1;
    sends = 4'b0100;
    interrupt_en = 1'b1;
    tick();
    total++;
    if (send_acks !== 4'b0100 || msg_bus !== 2'd2 || msg_valid !== 1'b1) begin
      bad++;
      $display("FAIL gate_release: got sa=%b bus=%0d v=%b, want sa=0100 bus=2 v=1",
               send_acks, msg_bus, msg_valid);
    end
    sends = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int acks = 0;
    datas[1] = 32'hDEAD_BEEF;
    sends = 4'b0010;
    msg_ready = 1'b0;
    tick();
    acks += $countones(send_acks);
    repeat (5) begin
      tick();
      acks += $countones(send_acks);
      total++;
      if (msg_valid !== 1'b1 || msg_data !== 32'hDEAD_BEEF || msg_bus !== 2'd1) begin
        bad++;
        $display("FAIL bp_hold: got v=%b bus=%0d data=%h, want v=1 bus=1 data=deadbeef",
                 msg_valid, msg_bus, msg_data);
      end
    end
    total++;
    if (acks != 1) begin
      bad++;
      $display("FAIL bp_single_ack: got %0d ack pulses, want 1", acks);
    end
    msg_ready = 1'b1;
    sends = '0;
    tick();
    total++;
    if (msg_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got v=%b, want v=0", msg_valid);
    end
  endtask

  task automatic test_reset_in_hold();
    sends = 4'b0001;
    msg_ready = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (msg_valid !== 1'b0 || send_acks !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold_async: got v=%b sa=%b, want v=0 sa=0000", msg_valid, send_acks);
    end
    #2;
    reset = 1'b1;
    tick();
    total++;
    if (send_acks !== 4'b0001 || msg_valid !== 1'b1 || msg_bus !== 2'd0) begin
      bad++;
      $display("FAIL reset_hold_regrant: got sa=%b v=%b bus=%0d, want sa=0001 v=1 bus=0",
               send_acks, msg_valid, msg_bus);
    end
    sends = '0;
    msg_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable       = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      kills        = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      sends        = N'($urandom);
      interrupt_en = ($urandom_range(0, 3) != 0);
      msg_ready    = $urandom_range(0, 1);
      for (int i = 0; i < N; i++) datas[i] = $urandom;
      tick();
      total++;
      if ({msg_valid, kill_acks, send_acks} !== {m_hold, m_kack, m_sack}) begin
        bad++;
        $display("FAIL rand_ctl%0d: got v=%b ka=%b sa=%b, want v=%b ka=%b sa=%b",
                 c, msg_valid, kill_acks, send_acks, m_hold, m_kack, m_sack);
      end
      if (m_hold) begin
        total++;
        if ({msg_kill, msg_bus, msg_data} !== {m_kill, IW'(m_bus), m_data}) begin
          bad++;
          $display("FAIL rand_msg%0d: got k=%b bus=%0d data=%h, want k=%b bus=%0d data=%h",
                   c, msg_kill, msg_bus, msg_data, m_kill, m_bus, m_data);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_kill_priority();
    test_round_robin();
    test_gating();
    test_backpressure();
    test_reset_in_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uarc_receiver_arbiter.md
# uarc_receiver_arbiter

Receive-side arbiter for the UARC bus fabric of core0. Watches every incoming bus's kill and send requests, picks one winner per transaction, and acknowledges the winning sender. Captures the winner's data word and presents it to the core's interrupt/kill logic through a single valid/ready port. Kills always beat sends; buses within a class are chosen round-robin, or by fixed priority, depending on configuration.

## Interface
Parameters:
- WORD_MAG, 5, log2 of word width; WORD_WIDTH = 1 << WORD_MAG
- TOTAL_BUSES, 4, number of receiver buses (1..WORD_WIDTH)
- IDX_WIDTH (localparam), max(1, $clog2(TOTAL_BUSES)), width of a bus index

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- receiver_enable  in  TOTAL_BUSES  bus is connected/enabled; disabled buses are never granted
- receiver_kills  in  TOTAL_BUSES  kill request per bus, level, held until acked
- receiver_kill_acks  out  TOTAL_BUSES  one-cycle grant pulse for kill
- receiver_sends  in  TOTAL_BUSES  send request per bus, level, held until acked
- receiver_send_acks  out  TOTAL_BUSES  one-cycle grant pulse for send
- receiver_datas  in  TOTAL_BUSES x WORD_WIDTH  per-bus data word
- interrupt_en  in  1  core accepts sends; kills are accepted regardless
- msg_valid  out  1  captured message available
- msg_kill  out  1  1 = kill, 0 = send
- msg_bus  out  IDX_WIDTH  index of granted bus
- msg_data  out  WORD_WIDTH  captured data; zero for kill
- msg_ready  in  1  core consumes message at edge where msg_valid & msg_ready

## Operation
- Eligibility: kill_elig = receiver_kills & receiver_enable; send_elig = receiver_sends & receiver_enable & {TOTAL_BUSES{interrupt_en}}.
- Class select: any kill_elig wins over all sends.
- Bus select within a class: first set bit starting from rr_ptr, ascending with wrap (TOTAL_BUSES-1 -> 0). With the macro absent, the lowest set index wins.
- FSM IDLE: if a winner exists, at the edge, capture the winner into msg_bus, msg_kill and msg_data. Raise the matching ack bit for exactly the following cycle. Set rr_ptr = (winner+1) mod TOTAL_BUSES (wrap, not power-of-2 truncation). Go to HOLD.
- FSM HOLD: msg_valid=1, outputs stable. On msg_ready, go to IDLE. No new grant is made while in HOLD.
- At most one ack bit is high across both ack vectors in any cycle.
- Request inputs are not registered; arbitration is combinational on the IDLE cycle's inputs.
- Reset values: msg_valid=0, msg_kill=0, msg_bus=0, msg_data=0, all acks=0, rr_ptr=0, state=IDLE.

## Timing
- Request sampled in IDLE cycle N -> ack high in cycle N+1 only; msg_valid high from N+1.
- Earliest consume is the edge ending N+1; then IDLE in N+2, where the next grant can be sampled. Throughput is 1 message per 2 cycles.
- Sender must drop its request by the edge ending its ack cycle. A request still high in the next IDLE cycle is treated as a new request.
- interrupt_en falling while in HOLD does not cancel the held send.
- Requests dropping before grant: never acked, no side effect.
- Reset asserted mid-HOLD: message discarded, acks cleared asynchronously, no ack re-issued.

## Configuration
- UARC_RECEIVER_ROUND_ROBIN_EN defined: rotating rr_ptr fairness as above, applied to both classes.
- Undefined: rr_ptr is removed and fixed lowest-index priority is used, matching the core's priority encoder ordering; all other behaviour is identical.

## Test plan
- Reset: reset=0 with sends=4'b1111 -> all outputs 0, no ack. Release reset -> first grant is bus 0, send_acks=4'b0001 for one cycle.
- Kill priority: sends=4'b0010, kills=4'b1000 in the same cycle -> msg_kill=1, msg_bus=3, kill_acks=4'b1000; the send is granted after consume.
- Round-robin (macro on): sends held at 4'b1011 and re-raised after each ack, msg_ready=1 -> grant order 0,1,3,0. Macro off -> 0,0,0...
- Gating: interrupt_en=0 with sends=4'b0100 -> no ack. enable=4'b1011 with kills=4'b0100 -> no ack. interrupt_en=1 -> bus 2 send granted.
- Backpressure: msg_ready=0 for 5 cycles with data 32'hDEADBEEF on bus 1 -> msg_valid and data stable, single ack pulse, no second grant. msg_ready=1 -> IDLE next cycle.
- Reset in HOLD: reset pulsed low while msg_valid=1 -> msg_valid=0 immediately; after release the same still-held request is granted fresh with a new ack.
